// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..DATA_W data bits, none/even/odd parity,
// 1 or 2 stop bits, with a one-entry holding register so frames can go out back-to-back.
module uart_tx_cfg #(
  parameter int unsigned SAMPLE = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_en,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [3:0]        cfg_nbits,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop,
  output logic              tx_busy,
  output logic              frame_done,
  output logic              tx
);

  localparam int unsigned CNT_W = (SAMPLE > 2) ? $clog2(SAMPLE) : 1;
  localparam int unsigned NB_W  = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE - 1);
  localparam logic [NB_W-1:0]  NB_MIN   = NB_W'(5);
  localparam logic [NB_W-1:0]  NB_MAX   = NB_W'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Holding register (one word plus its frame config)
  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  logic [NB_W-1:0]   hold_nbits;
  logic              hold_par_en;
  logic              hold_par_bit;
  logic              hold_stop2;

  // Active frame
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [NB_W-1:0]   f_nbits;
  logic              f_par_en;
  logic              f_par_bit;
  logic              f_stop2;
  logic [CNT_W-1:0]  cnt;
  logic [NB_W-1:0]   bit_idx;

  logic              accept;
  logic              bit_end;
  logic              last_data;
  logic              last_stop;
  logic              frame_end;
  logic              load;
  logic [NB_W-1:0]   nbits_clamp;
  logic [DATA_W-1:0] data_mask;
  logic [DATA_W-1:0] data_masked;
  logic              tx_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  assign tx_ready  = ~hold_full;
  assign accept    = tx_valid & ~hold_full;
  assign bit_end   = baud_en & (cnt == CNT_LAST);
  assign last_data = (bit_idx == (f_nbits - NB_W'(1)));
  assign last_stop = (bit_idx == NB_W'(f_stop2));
  assign frame_end = (state == S_STOP) & bit_end & last_stop;
  assign load      = hold_full & ((state == S_IDLE) | frame_end);

  // Clamp requested length and drop data bits beyond it
  always_comb begin
    nbits_clamp = cfg_nbits;
    if (cfg_nbits < NB_MIN) begin
      nbits_clamp = NB_MIN;
    end else if (cfg_nbits > NB_MAX) begin
      nbits_clamp = NB_MAX;
    end
    data_mask = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      data_mask[i] = (NB_W'(i) < nbits_clamp);
    end
  end

  assign data_masked = tx_data & data_mask;

  always_comb begin
    shreg_nxt = shreg;
    if (load) begin
      shreg_nxt = hold_data;
    end else if ((state == S_DATA) && bit_end) begin
      shreg_nxt = shreg >> 1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (hold_full) state_nxt = S_START;
      S_START:  if (bit_end) state_nxt = S_DATA;
      S_DATA:   if (bit_end && last_data) state_nxt = f_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_nxt = S_STOP;
      S_STOP:   if (frame_end) state_nxt = hold_full ? S_START : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic, evaluated against the upcoming state so tx can be registered
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = frame_end;
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shreg_nxt[0];
      S_PARITY: tx_nxt = f_par_bit;
      default:  tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx         <= tx_nxt;
      tx_busy    <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

  // Holding register, frame config, bit timing
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full    <= 1'b0;
      hold_data    <= '0;
      hold_nbits   <= NB_MIN;
      hold_par_en  <= 1'b0;
      hold_par_bit <= 1'b0;
      hold_stop2   <= 1'b0;
      shreg        <= '0;
      f_nbits      <= NB_MIN;
      f_par_en     <= 1'b0;
      f_par_bit    <= 1'b0;
      f_stop2      <= 1'b0;
      cnt          <= '0;
      bit_idx      <= '0;
    end else begin
      if (accept) begin
        hold_full    <= 1'b1;
        hold_data    <= data_masked;
        hold_nbits   <= nbits_clamp;
        hold_par_en  <= cfg_parity[0] ^ cfg_parity[1];
        hold_par_bit <= (^data_masked) ^ cfg_parity[1];
        hold_stop2   <= cfg_stop;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      shreg <= shreg_nxt;

      if (load) begin
        f_nbits   <= hold_nbits;
        f_par_en  <= hold_par_en;
        f_par_bit <= hold_par_bit;
        f_stop2   <= hold_stop2;
      end

      if (load || (state == S_IDLE)) begin
        cnt <= '0;
      end else if (baud_en) begin
        cnt <= bit_end ? '0 : cnt + CNT_W'(1);
      end

      // Indexes data bits in DATA and stop bits in STOP
      if (load || (state_nxt != state)) begin
        bit_idx <= '0;
      end else if (bit_end && ((state == S_DATA) || (state == S_STOP))) begin
        bit_idx <= bit_idx + NB_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: a line monitor decodes frames by counting baud ticks
// and compares them against frames queued by an independent model at accept time.
module tb_uart_tx_cfg;

  localparam int unsigned SAMPLE = 4;
  localparam int unsigned DATA_W = 8;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  logic             clk;
  logic             rst;
  logic             baud_en;
  logic [DATA_W-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [3:0]       cfg_nbits;
  logic [1:0]       cfg_parity;
  logic             cfg_stop;
  logic             tx_busy;
  logic             frame_done;
  logic             tx;

  int     n_assert = 0;
  int     n_fail = 0;
  int     frames_seen = 0;
  int     gapless_cnt = 0;
  int     baud_mode = 0;
  frame_t exp_q[$];

  uart_tx_cfg #(.SAMPLE(SAMPLE), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .baud_en(baud_en), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .cfg_nbits(cfg_nbits), .cfg_parity(cfg_parity), .cfg_stop(cfg_stop),
    .tx_busy(tx_busy), .frame_done(frame_done), .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // baud_en changes 2 time units after the rising edge; mode 0 always, 1 every 3rd clk, 2 held low
  initial begin
    int div;
    div = 0;
    baud_en = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      div = (div == 2) ? 0 : div + 1;
      case (baud_mode)
        0:       baud_en = 1'b1;
        1:       baud_en = (div == 0);
        default: baud_en = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t make_frame(input logic [7:0] d, input int nb,
                                        input logic [1:0] par, input logic st);
    frame_t f;
    int     n;
    logic   p;
    n = (nb < 5) ? 5 : ((nb > 8) ? 8 : nb);
    f.bits = '0;
    p = 1'b0;
    f.bits[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      f.bits[1 + i] = d[i];
      p = p ^ d[i];
    end
    f.len = 1 + n;
    if (par == 2'b01) begin
      f.bits[f.len] = p;
      f.len = f.len + 1;
    end else if (par == 2'b10) begin
      f.bits[f.len] = ~p;
      f.len = f.len + 1;
    end
    f.bits[f.len] = 1'b1;
    f.len = f.len + 1;
    if (st) begin
      f.bits[f.len] = 1'b1;
      f.len = f.len + 1;
    end
    return f;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accept edge
  task automatic send(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] par,
                      input logic st);
    int g;
    g = 0;
    while (!tx_ready && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("send_ready_wait", 32'(tx_ready), 32'd1);
    tx_data    = d;
    cfg_nbits  = nb;
    cfg_parity = par;
    cfg_stop   = st;
    tx_valid   = 1'b1;
    exp_q.push_back(make_frame(d, int'(nb), par, st));
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output int ticks, output int first_tick);
    cycles = 0;
    ticks = 0;
    first_tick = -1;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      if (baud_en) begin
        ticks++;
        if (first_tick < 0) first_tick = cycles;
      end
    end while (frame_done !== 1'b1 && cycles < 5000);
    check("frame_done_seen", 32'(frame_done), 32'd1);
  endtask

  // Decode one frame starting at the current falling edge (first edge of the start bit)
  task automatic mon_frame(output logic chain_o, output logic abort_o);
    frame_t      ef;
    logic [15:0] got;
    int          t;
    int          g;
    chain_o = 1'b0;
    abort_o = 1'b0;
    got = '0;
    check("start_expected", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) begin
      abort_o = 1'b1;
      return;
    end
    ef = exp_q.pop_front();
    frames_seen++;
    for (int b = 0; b < ef.len; b++) begin
      t = 0;
      g = 0;
      while (t < int'(SAMPLE)) begin
        if (rst) begin
          abort_o = 1'b1;
          return;
        end
        if (baud_en) begin
          t++;
          if (t == int'(SAMPLE) / 2) got[b] = tx;
        end
        if (t < int'(SAMPLE)) begin
          @(negedge clk);
          g++;
          if (g > 5000) begin
            check("mon_bit_timeout", 32'(g), 32'd0);
            abort_o = 1'b1;
            return;
          end
        end
      end
      @(negedge clk);
    end
    if (rst) begin
      abort_o = 1'b1;
      return;
    end
    check($sformatf("frame%0d_bits", frames_seen), 32'(got), 32'(ef.bits));
    check($sformatf("frame%0d_done_pulse", frames_seen), 32'(frame_done), 32'd1);
    chain_o = (tx === 1'b0);
  endtask

  initial begin
    logic prev;
    logic chain;
    logic ab;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && prev === 1'b1 && tx === 1'b0) begin
        do begin
          mon_frame(chain, ab);
          if (chain && !ab) gapless_cnt++;
        end while (chain && !ab);
      end
      prev = tx;
    end
  end

  initial begin
    int   cyc;
    int   tk;
    int   ft;
    int   n;
    int   gap0;
    int   fs;
    logic saved;
    logic ok;

    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = '0;
    cfg_nbits = 4'd8;
    cfg_parity = 2'b00;
    cfg_stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_ready", 32'(tx_ready), 32'd1);
    check("reset_done", 32'(frame_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // 8N1 0xA5: start 2 edges after accept, 40 clk frame
    send(8'hA5, 4'd8, 2'b00, 1'b0);
    check("t1_tx_high_at_accept", 32'(tx), 32'd1);
    @(posedge clk);
    #1;
    check("t1_start_latency", 32'(tx), 32'd0);
    check("t1_busy", 32'(tx_busy), 32'd1);
    wait_done(cyc, tk, ft);
    check("t1_frame_clk", 32'(cyc), 32'd40);
    check("t1_busy_after", 32'(tx_busy), 32'd0);
    @(posedge clk);
    #1;
    check("t1_done_one_clk", 32'(frame_done), 32'd0);

    // 8E1 and 8O1 with 0x07
    send(8'h07, 4'd8, 2'b01, 1'b0);
    @(posedge clk);
    #1;
    wait_done(cyc, tk, ft);
    check("t2_8e1_clk", 32'(cyc), 32'd44);
    send(8'h07, 4'd8, 2'b10, 1'b0);
    @(posedge clk);
    #1;
    wait_done(cyc, tk, ft);
    check("t2_8o1_clk", 32'(cyc), 32'd44);

    // 7O2 with bit 7 set, then a length below the minimum
    send(8'hD5, 4'd7, 2'b10, 1'b1);
    @(posedge clk);
    #1;
    wait_done(cyc, tk, ft);
    check("t3_7o2_clk", 32'(cyc), 32'd44);
    send(8'hF3, 4'd3, 2'b11, 1'b0);
    @(posedge clk);
    #1;
    wait_done(cyc, tk, ft);
    check("t3_clamp5_clk", 32'(cyc), 32'd28);

    // Back-to-back frames through the holding register
    gap0 = gapless_cnt;
    send(8'h12, 4'd8, 2'b00, 1'b0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    send(8'h34, 4'd8, 2'b00, 1'b0);
    check("t4_ready_low_held", 32'(tx_ready), 32'd0);
    tx_data = 8'h56;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t4_hold_clk", 32'(n), 32'd32);
    check("t4_reload_with_done", 32'(frame_done), 32'd1);
    check("t4_no_gap_start", 32'(tx), 32'd0);
    exp_q.push_back(make_frame(8'h56, 8, 2'b00, 1'b0));
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    n = 0;
    while (tx_busy && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t4_busy_clears", 32'(tx_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("t4_gapless_frames", 32'(gapless_cnt - gap0), 32'd2);

    // baud_en every 3rd clk: 40 ticks, consecutive ticks 3 clk apart
    baud_mode = 1;
    send(8'h3C, 4'd8, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    check("t5_start_latency", 32'(tx), 32'd0);
    wait_done(cyc, tk, ft);
    check("t5_ticks", 32'(tk), 32'd40);
    check("t5_span_clk", 32'(cyc - ft), 32'd117);
    baud_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    // baud_en held low mid-bit freezes tx and stretches the frame
    send(8'h3D, 4'd8, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    saved = tx;
    check("t5_bit0_value", 32'(saved), 32'd1);
    baud_mode = 2;
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (tx !== saved || frame_done !== 1'b0) ok = 1'b0;
    end
    check("t5_frozen", 32'(ok), 32'd1);
    baud_mode = 0;
    wait_done(cyc, tk, ft);
    check("t5_remaining_clk", 32'(cyc), 32'd34);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-frame with a word held
    send(8'hAA, 4'd8, 2'b00, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    send(8'hBB, 4'd8, 2'b00, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_tx", 32'(tx), 32'd1);
    check("t6_busy", 32'(tx_busy), 32'd0);
    check("t6_ready", 32'(tx_ready), 32'd1);
    check("t6_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    fs = frames_seen;
    ok = 1'b1;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
    end
    check("t6_line_idle", 32'(ok), 32'd1);
    check("t6_no_held_frame", 32'(frames_seen - fs), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
